// File: rtl/sd_data_xfer_seq.sv
// sd_data_xfer_seq: multi-block transfer sequencer that drives the SD data
// serial host start[1:0] handshake, running one single-block host cycle per
// block and accumulating block progress and sticky error status.
// Optional feature macro: SD_XFER_WATCHDOG_EN adds a per-block RUN watchdog.
module sd_data_xfer_seq #(
  parameter int BLKCNT_W = 16,
  parameter int WDOG_W   = 24
) (
  input  logic                sd_clk,
  input  logic                rst,
  input  logic                xfer_rd_i,
  input  logic                xfer_wr_i,
  input  logic                xfer_abort_i,
  input  logic [BLKCNT_W-1:0] blkcnt_i,
  input  logic [31:0]         timeout_i,
  output logic [1:0]          host_start_o,
  input  logic                host_busy_i,
  input  logic                host_finish_i,
  input  logic                host_crc_ok_i,
  input  logic [31:0]         host_wait_i,
  output logic                xfer_busy_o,
  output logic                xfer_done_o,
  output logic [BLKCNT_W-1:0] blk_done_o,
  output logic                err_crc_o,
  output logic                err_timeout_o,
  output logic                err_abort_o
);

  if (WDOG_W < 2) begin : g_bad_wdog
    $error("WDOG_W must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_CHECK, S_DRAIN, S_ABORT, S_DONE
  } state_t;

  localparam logic [1:0] START_IDLE  = 2'b00;
  localparam logic [1:0] START_WRITE = 2'b01;
  localparam logic [1:0] START_READ  = 2'b10;
  localparam logic [1:0] START_ABORT = 2'b11;

  state_t                state_q;
  logic                  dir_rd_q;
  logic [BLKCNT_W-1:0]   cnt_q;
  logic [BLKCNT_W-1:0]   blk_done_q;
  logic [BLKCNT_W-1:0]   blk_done_d;
  logic [1:0]            start_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_crc_q;
  logic                  err_to_q;
  logic                  err_abort_q;
  logic                  err_any;
`ifdef SD_XFER_WATCHDOG_EN
  logic [WDOG_W-1:0]     wdog_q;
`endif

  // Saturating block-progress increment and combined sticky error view.
  always_comb begin
    blk_done_d = blk_done_q;
    if (blk_done_q != '1) begin
      blk_done_d = blk_done_q + 1'b1;
    end
    err_any = err_crc_q | err_to_q | err_abort_q;
  end

  // Transfer sequencer FSM with registered host handshake and status.
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dir_rd_q    <= 1'b0;
      cnt_q       <= '0;
      blk_done_q  <= '0;
      start_q     <= START_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_crc_q   <= 1'b0;
      err_to_q    <= 1'b0;
      err_abort_q <= 1'b0;
`ifdef SD_XFER_WATCHDOG_EN
      wdog_q      <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (xfer_wr_i || xfer_rd_i) begin
            blk_done_q  <= '0;
            err_crc_q   <= 1'b0;
            err_to_q    <= 1'b0;
            err_abort_q <= 1'b0;
            dir_rd_q    <= ~xfer_wr_i;
            cnt_q       <= blkcnt_i;
            if (blkcnt_i == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              start_q <= xfer_wr_i ? START_WRITE : START_READ;
`ifdef SD_XFER_WATCHDOG_EN
              wdog_q  <= '0;
`endif
            end
          end
        end
        S_RUN: begin
          if (xfer_abort_i) begin
            state_q     <= S_ABORT;
            start_q     <= START_ABORT;
            err_abort_q <= 1'b1;
          end else if (host_finish_i) begin
            state_q <= S_CHECK;
            start_q <= START_IDLE;
          end
`ifdef SD_XFER_WATCHDOG_EN
          else if (&wdog_q) begin
            state_q     <= S_ABORT;
            start_q     <= START_ABORT;
            err_abort_q <= 1'b1;
            err_to_q    <= 1'b1;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
`endif
        end
        S_CHECK: begin
          if (xfer_abort_i) begin
            state_q     <= S_ABORT;
            start_q     <= START_ABORT;
            err_abort_q <= 1'b1;
          end else begin
            state_q <= S_DRAIN;
            if (dir_rd_q && !host_crc_ok_i) begin
              if (host_wait_i >= timeout_i) begin
                err_to_q <= 1'b1;
              end else begin
                err_crc_q <= 1'b1;
              end
            end else begin
              blk_done_q <= blk_done_d;
            end
          end
        end
        S_DRAIN: begin
          if (xfer_abort_i) begin
            state_q     <= S_ABORT;
            start_q     <= START_ABORT;
            err_abort_q <= 1'b1;
          end else if (!host_finish_i && !host_busy_i) begin
            if (err_any || (blk_done_q == cnt_q)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
              start_q <= dir_rd_q ? START_READ : START_WRITE;
`ifdef SD_XFER_WATCHDOG_EN
              wdog_q  <= '0;
`endif
            end
          end
        end
        S_ABORT: begin
          state_q <= S_DRAIN;
          start_q <= START_IDLE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          start_q <= START_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign host_start_o  = start_q;
  assign xfer_busy_o   = busy_q;
  assign xfer_done_o   = done_q;
  assign blk_done_o    = blk_done_q;
  assign err_crc_o     = err_crc_q;
  assign err_timeout_o = err_to_q;
  assign err_abort_o   = err_abort_q;

endmodule
